// File: rtl/exception_ctrl_if.sv
// Purpose : bundles the MEM-stage exception/CP0 signals between the pipeline and exception_ctrl.
// Latency : wires only; no storage.
// Backpressure: none; every field is sampled or driven each cycle.
// Ports (master = pipeline side, slave = exception_ctrl):
//   mem_valid, mem_pc, mem_in_ds, mem_bad_addr, exc_* flags, mem_eret, hw_int,
//   cp0_we, cp0_waddr, cp0_raddr, cp0_wdata      : master -> slave
//   cp0_rdata, flush, pc_redirect, exception_pc, exl : slave -> master
interface exception_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_ds;
  logic [31:0] mem_bad_addr;
  logic        exc_adel_if;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_adel_ld;
  logic        exc_ades;
  logic        mem_eret;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] exception_pc;
  logic        exl;

  modport master (
    output mem_valid, mem_pc, mem_in_ds, mem_bad_addr,
           exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades,
           mem_eret, hw_int, cp0_we, cp0_waddr, cp0_raddr, cp0_wdata,
    input  cp0_rdata, flush, pc_redirect, exception_pc, exl
  );

  modport slave (
    input  mem_valid, mem_pc, mem_in_ds, mem_bad_addr,
           exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_ld, exc_ades,
           mem_eret, hw_int, cp0_we, cp0_waddr, cp0_raddr, cp0_wdata,
    output cp0_rdata, flush, pc_redirect, exception_pc, exl
  );
endinterface

// File: rtl/exception_ctrl.sv
// Purpose : CP0-lite exception controller; prioritises MEM-stage exceptions/interrupts,
//           holds Status/Cause/EPC/BadVAddr/Count/Compare, sequences ERET, serves MTC0/MFC0.
// Latency : flush/pc_redirect/exception_pc and cp0_rdata are combinational (0 cycles);
//           CP0 state updates at the same edge the PC register takes the redirect.
// Backpressure: none; an event is acted on in the cycle it is presented.
// Ports   : clk, rst (sync, active-high); cp0_if (slave modport) carries MEM inputs,
//           CP0 read/write port and the flush/redirect outputs.
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic               clk,
  input  logic               rst,
  exception_ctrl_if.slave    cp0_if
);

  localparam logic [4:0] A_BADVADDR = 5'd8;
  localparam logic [4:0] A_COUNT    = 5'd9;
  localparam logic [4:0] A_COMPARE  = 5'd11;
  localparam logic [4:0] A_STATUS   = 5'd12;
  localparam logic [4:0] A_CAUSE    = 5'd13;
  localparam logic [4:0] A_EPC      = 5'd14;

  localparam logic [4:0] EC_INT  = 5'd0;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_ADES = 5'd5;
  localparam logic [4:0] EC_SYS  = 5'd8;
  localparam logic [4:0] EC_BP   = 5'd9;
  localparam logic [4:0] EC_RI   = 5'd10;
  localparam logic [4:0] EC_OV   = 5'd12;

  // Status fields
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic        r_ti;
  logic [7:0]  r_ip;
  logic [4:0]  r_exccode;
  // Full-width registers
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;

  logic        w_int_p;
  logic        w_any_flag;
  logic        w_exc_take;
  logic        w_eret_take;
  logic [4:0]  w_exc_code;
  logic        w_badv_load;
  logic [31:0] w_badv_val;
  logic        w_wr;
  logic [31:0] w_count_nxt;
  logic [31:0] w_status_word;
  logic [31:0] w_cause_word;

  assign w_int_p    = r_ie & ~r_exl & (|(r_ip & r_im));
  assign w_any_flag = cp0_if.exc_adel_if | cp0_if.exc_ri | cp0_if.exc_ov | cp0_if.exc_sys |
                      cp0_if.exc_bp | cp0_if.exc_adel_ld | cp0_if.exc_ades;
  // Reset masks the event so neither state nor flush reacts during rst.
  assign w_exc_take  = ~rst & cp0_if.mem_valid & (w_int_p | w_any_flag);
  assign w_eret_take = ~rst & cp0_if.mem_valid & cp0_if.mem_eret & ~w_exc_take;
  // An MTC0 colliding with an exception is squashed along with its instruction.
  assign w_wr        = cp0_if.cp0_we & cp0_if.mem_valid & ~w_exc_take;

  // Priority encoder; also selects which address (if any) lands in BadVAddr.
  always_comb begin
    w_exc_code  = EC_INT;
    w_badv_load = 1'b0;
    w_badv_val  = cp0_if.mem_bad_addr;
    if (w_int_p) begin
      w_exc_code = EC_INT;
    end else if (cp0_if.exc_adel_if) begin
      w_exc_code  = EC_ADEL;
      w_badv_load = 1'b1;
      w_badv_val  = cp0_if.mem_pc;
    end else if (cp0_if.exc_ri) begin
      w_exc_code = EC_RI;
    end else if (cp0_if.exc_ov) begin
      w_exc_code = EC_OV;
    end else if (cp0_if.exc_sys) begin
      w_exc_code = EC_SYS;
    end else if (cp0_if.exc_bp) begin
      w_exc_code = EC_BP;
    end else if (cp0_if.exc_adel_ld) begin
      w_exc_code  = EC_ADEL;
      w_badv_load = 1'b1;
    end else if (cp0_if.exc_ades) begin
      w_exc_code  = EC_ADES;
      w_badv_load = 1'b1;
    end
  end

  assign w_count_nxt = (w_wr && cp0_if.cp0_waddr == A_COUNT) ? cp0_if.cp0_wdata
                                                             : r_count + 32'd1;

  assign w_status_word = {16'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause_word  = {r_bd, r_ti, 14'd0, r_ip, 1'b0, r_exccode, 2'b00};

  always_comb begin
    cp0_if.cp0_rdata = 32'd0;
    case (cp0_if.cp0_raddr)
      A_BADVADDR: cp0_if.cp0_rdata = r_badvaddr;
      A_COUNT:    cp0_if.cp0_rdata = r_count;
      A_COMPARE:  cp0_if.cp0_rdata = r_compare;
      A_STATUS:   cp0_if.cp0_rdata = w_status_word;
      A_CAUSE:    cp0_if.cp0_rdata = w_cause_word;
      A_EPC:      cp0_if.cp0_rdata = r_epc;
      default:    cp0_if.cp0_rdata = 32'd0;
    endcase
  end

  assign cp0_if.flush        = w_exc_take | w_eret_take;
  assign cp0_if.pc_redirect  = w_exc_take | w_eret_take;
  assign cp0_if.exception_pc = w_exc_take  ? EXC_VECTOR :
                               w_eret_take ? r_epc      : 32'd0;
  assign cp0_if.exl          = r_exl;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im       <= '0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_ti       <= 1'b0;
      r_ip       <= '0;
      r_exccode  <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
      r_count    <= '0;
      r_compare  <= '0;
    end else begin
      r_count <= w_count_nxt;

      // Compare write clears TI and beats a same-cycle match.
      if (w_wr && cp0_if.cp0_waddr == A_COMPARE) begin
        r_ti <= 1'b0;
      end else if (w_count_nxt == r_compare) begin
        r_ti <= 1'b1;
      end

      // Hardware lines and timer fold into IP[7:2] one cycle late.
      r_ip[7:2] <= {cp0_if.hw_int[5] | r_ti, cp0_if.hw_int[4:0]};

      if (w_wr) begin
        case (cp0_if.cp0_waddr)
          A_BADVADDR: r_badvaddr <= cp0_if.cp0_wdata;
          A_COMPARE:  r_compare  <= cp0_if.cp0_wdata;
          A_STATUS: begin
            r_im  <= cp0_if.cp0_wdata[15:8];
            r_exl <= cp0_if.cp0_wdata[1];
            r_ie  <= cp0_if.cp0_wdata[0];
          end
          A_CAUSE:    r_ip[1:0]  <= cp0_if.cp0_wdata[9:8];
          A_EPC:      r_epc      <= cp0_if.cp0_wdata;
          default: ;
        endcase
      end

      if (w_exc_take) begin
        r_exccode <= w_exc_code;
        // Nested exceptions keep the original return point.
        if (!r_exl) begin
          r_epc <= cp0_if.mem_in_ds ? cp0_if.mem_pc - 32'd4 : cp0_if.mem_pc;
          r_bd  <= cp0_if.mem_in_ds;
        end
        r_exl <= 1'b1;
        if (w_badv_load) begin
          r_badvaddr <= w_badv_val;
        end
      end else if (w_eret_take) begin
        r_exl <= 1'b0;
      end
    end
  end

endmodule
